// File: rtl/arbiter_pkg.sv
// arbiter_pkg: shared types, limits and helpers for the H-to-V request arbiter
package arbiter_pkg;
    localparam int ARB_MAX_REQ = 32;
    localparam int ARB_IDX_W = $clog2(ARB_MAX_REQ);
    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;
    function automatic logic [ARB_IDX_W-1:0] onehot_to_idx(input logic [ARB_MAX_REQ-1:0] oh);
        logic [ARB_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_MAX_REQ; i++) idx = oh[i] ? (idx | ARB_IDX_W'(i)) : idx;
        return idx;
    endfunction
endpackage

// File: rtl/arbiter_rr_pick.sv
// arbiter_rr_pick: combinational winner search, descending from ptr-1 (ptr forced to 0 in fixed mode)
module arbiter_rr_pick #(
    parameter int NUM_REQ = 6,
    parameter int IDX_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               mode_rr,
    output logic [NUM_REQ-1:0] win,
    output logic [IDX_W-1:0]   win_idx
);
    localparam logic [IDX_W:0] NUM_W = (IDX_W+1)'(NUM_REQ);
    logic [IDX_W-1:0]   eff_ptr;
    logic [IDX_W-1:0]   enc;
    logic [NUM_REQ-1:0] rot;
    logic [NUM_REQ-1:0] win_rot;
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b);
        logic [IDX_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= NUM_W) ? IDX_W'(s - NUM_W) : s[IDX_W-1:0];
    endfunction
    // rotate so ptr-1 lands on the top bit, take the highest set bit, rotate the result back
    always_comb begin
        eff_ptr = mode_rr ? ptr : '0;
        rot     = '0;
        enc     = '0;
        win     = '0;
        for (int i = 0; i < NUM_REQ; i++) rot[i] = req[wrap_add(IDX_W'(i), eff_ptr)];
        for (int i = 0; i < NUM_REQ; i++) enc = rot[i] ? IDX_W'(i) : enc;
        win_rot = (|rot) ? (NUM_REQ'(1) << enc) : '0;
        for (int i = 0; i < NUM_REQ; i++) win[wrap_add(IDX_W'(i), eff_ptr)] = win_rot[i];
        win_idx = (|rot) ? wrap_add(enc, eff_ptr) : '0;
    end
endmodule

// File: rtl/system_define.sv
// system_define: system-wide core counts for the H-to-V interconnect
`ifndef SYSTEM_DEFINE_SV
`define SYSTEM_DEFINE_SV
`define NUM_CORE_H 6
`endif

// File: rtl/arbiter_rr_hv.sv
// arbiter_rr_hv: registered fixed/round-robin arbiter with grant hold and timeout preemption
`include "system_define.sv"
module arbiter_rr_hv
    import arbiter_pkg::*;
#(
    parameter int NUM_REQ = `NUM_CORE_H,
    parameter int MAX_HOLD = 16,
    parameter int IDX_W = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode_rr,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               preempt
);
    localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               preempt_q, preempt_d;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               own_req;
    logic               timeout;
    arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .mode_rr (mode_rr),
        .win     (pick_grant),
        .win_idx (pick_idx)
    );
    assign own_req = |(req & grant_q);
    assign timeout = (MAX_HOLD != 0) && (hold_q == HOLD_LAST) && (|(req & ~grant_q));
    // next state: arbitrate in IDLE; in GRANT hold, or drop on release / contended timeout
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        preempt_d = 1'b0;
        if (state_q == ARB_IDLE) begin
            if (|req) begin
                state_d = ARB_GRANT;
                grant_d = pick_grant;
                idx_d   = pick_idx;
                valid_d = 1'b1;
                hold_d  = '0;
            end
        end else if (!own_req || timeout) begin
            state_d   = ARB_IDLE;
            grant_d   = '0;
            idx_d     = '0;
            valid_d   = 1'b0;
            ptr_d     = idx_q;
            hold_d    = '0;
            preempt_d = own_req;
        end else begin
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
        end
    end
    // state and output registers; reset drops any grant at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            grant_q   <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            preempt_q <= preempt_d;
        end
    end
    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_idx   = idx_q;
    assign preempt     = preempt_q;
    grant_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
    grant_idx_a: assert property (@(posedge clk) disable iff (!rst_n)
        valid_q |-> (onehot_to_idx(ARB_MAX_REQ'(grant_q)) == ARB_IDX_W'(idx_q)));
endmodule

// File: doc/arbiter_rr_hv.md
Name: arbiter_rr_hv

Overview:
- Parametrised, registered arbiter for the H-to-V core interconnect.
- Selects one of NUM_REQ requesting cores and holds the grant until the owner releases it or a hold timeout preempts it.
- Runtime mode selection:
  - fixed priority: highest index wins.
  - round-robin: descending, starting just below the last owner.
- Sits between the core request lines and the shared bus/buffer port. Replaces the fixed 6-core combinational priority encoder.

Parameters:
- NUM_REQ, `NUM_CORE_H (6), number of requesters; legal range 2..32.
- MAX_HOLD, 16, maximum consecutive grant cycles while other requests are pending; 0 disables preemption.
- IDX_W, $clog2(NUM_REQ), width of grant_idx; derived, not overridden.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- mode_rr  input  1  0 = fixed priority (highest index wins), 1 = round-robin; sampled only in IDLE.
- req  input  NUM_REQ  per-core request; level, held high for the whole transaction.
- grant  output  NUM_REQ  one-hot grant, registered; all-zero when no owner.
- grant_valid  output  1  OR of grant, registered.
- grant_idx  output  IDX_W  binary index of owner; 0 when grant_valid = 0.
- preempt  output  1  one-cycle pulse on the cycle the grant is removed by timeout.

Behaviour:
- Reset (async assert, sync release):
  - grant = 0, grant_valid = 0, grant_idx = 0, preempt = 0.
  - state = IDLE, ptr = 0, hold_cnt = 0.
  - Reset mid-grant drops grant immediately; no preempt pulse.
- One clock domain; no combinational path from req to any output.
- States: IDLE, GRANT.
- IDLE:
  - If req != 0 at edge k, the winner is registered and visible after edge k (latency 1 cycle); state -> GRANT, hold_cnt = 0.
  - If req == 0, outputs stay 0.
- Winner selection:
  - Fixed mode: highest set index.
  - RR mode: search order (ptr-1) mod NUM_REQ, (ptr-2) mod NUM_REQ, ..., ptr, wrapping.
  - Reset ptr = 0, so the first RR arbitration matches fixed priority.
- GRANT:
  - If req[owner] = 1 and no preemption condition holds: grant unchanged; hold_cnt increments, saturating at MAX_HOLD.
  - If req[owner] = 0 at an edge (release): grant -> 0, ptr = owner, state -> IDLE. At least one idle turnaround cycle always follows any grant; there is no back-to-back re-grant.
  - Preemption condition: MAX_HOLD != 0, hold_cnt == MAX_HOLD-1, and (req & ~grant) != 0. On that edge: grant -> 0, preempt = 1 for one cycle, ptr = owner, state -> IDLE.
  - With MAX_HOLD = M the owner holds exactly M cycles when contended.
  - If there are no other requesters at timeout, no preemption occurs; hold_cnt stays saturated and the grant continues.
  - Release and timeout in the same cycle: release wins, preempt = 0.
- Requests not granted are not latched; a request dropped before arbitration is forgotten.
- mode_rr changes during GRANT take effect at the next IDLE arbitration.
- ptr is updated in both modes but used only in RR mode.
- grant always matches onehot(grant_idx) when valid. grant is never multi-hot; assertion required.

Decomposition:
- Package arbiter_pkg:
  - state enum (ARB_IDLE, ARB_GRANT).
  - function onehot_to_idx.
  - constant ARB_MAX_REQ = 32.
- Sub-module arbiter_rr_pick (combinational): inputs req, ptr, mode_rr; outputs one-hot winner and its index. Implemented as rotate, fixed-priority encode, rotate back.
- Top holds the FSM, ptr, hold_cnt and output registers.
- `NUM_CORE_H comes from system_define.sv.

Test Plan (NUM_REQ = 6, MAX_HOLD = 4):
- Reset with req = 6'b111111 held -> all outputs 0 during reset; first edge after release: grant = 6'b100000, idx = 5.
- Fixed mode:
  - req = 6'b010110, owner 4 releases, idle cycle -> next grant again 6'b010000 (idx 4) while req[4] is reasserted.
  - With req[4] low, next grant is idx 2.
- RR mode, req = 6'b111111 held except the owner drops for one cycle after each grant -> grant sequence idx 5,4,3,2,1,0,5, each separated by one idle cycle.
- RR mode, only req[1] high, holding for 10 cycles -> grant held 10 cycles, preempt never asserts.
- RR mode, req[3] owner holding, req[0] raised on the owner's 2nd grant cycle -> grant drops after exactly 4 grant cycles, preempt = 1 for one cycle, next grant = idx 0.
- Assert rst_n low in the middle of a grant -> grant = 0 asynchronously, without waiting for clk; after release, the RR pointer restarts (first winner is the highest pending index).
